pressure_needle_ctrl: RTL and testbench
=======================================

Name: pressure_needle_ctrl

Overview:
Parametrised successor of the pressure-meter needle counter. It computes a target pressure level from piston border position, temperature and mole count. It then slews the displayed needle position toward that target at a programmable rate, one step per prescaled tick. It adds hold, a settled flag, direction outputs and a hysteretic over-pressure alarm, and sits between the input-control logic and the VGA meter renderer.

Parameters:
Q_W, 7, width of needle position and target
BORDER_W, 8, width of border input
LVL_W, 3, width of temp and num_moles inputs
VOL_STEP, 50, border units per volume bucket
NUM_VOL_LVL, 5, number of volume buckets (max vol level)
SCALE, 5, multiplier applied to level sum
STEP_DIV, 4, enabled clocks per needle step (>=1)
RESET_POS, 30, needle position after reset
ALARM_LVL, 60, alarm assert threshold (Q >= ALARM_LVL)
ALARM_HYST, 4, alarm deasserts when Q < ALARM_LVL-ALARM_HYST

Ports:
clk  in  1  system clock, all state on rising edge
clearn  in  1  asynchronous active-low reset
enable  in  1  needle motion enable
hold  in  1  freeze needle and prescaler (target still tracks)
temp  in  LVL_W  temperature level
num_moles  in  LVL_W  mole-count level
border  in  BORDER_W  piston border position
Q  out  Q_W  needle position
target  out  Q_W  registered target pressure level
settled  out  1  Q == target and state SETTLED
dir_up  out  1  state RISE
dir_down  out  1  state FALL
alarm  out  1  over-pressure alarm

Behaviour:
- Reset (clearn=0, async): Q=RESET_POS, target=RESET_POS, prescaler=0, state=SETTLED, alarm=0.
- vol_lvl = min(border/VOL_STEP + 1, NUM_VOL_LVL).
- sum = (vol_lvl + temp + num_moles) * SCALE, computed at full width, saturated to 2^Q_W-1.
- target register loads sum every clock, regardless of enable/hold (1-cycle latency).
- State register updated every clock from Q vs target: SETTLED if equal, RISE if target>Q, FALL if target<Q.
- Prescaler:
  - Counts only when enable=1, hold=0 and state is RISE or FALL.
  - Steps when the count is STEP_DIV-1, then wraps to 0.
  - On a step, Q moves ±1 toward target. It never overshoots; the step is suppressed if Q==target.
  - Cleared on entry to SETTLED and on any RISE<->FALL reversal.
- Latency: input change at edge 0 -> target at edge 1 -> state at edge 2 -> first step at edge 2+STEP_DIV -> subsequent steps every STEP_DIV edges.
- Target change mid-slew: direction re-evaluated next edge; no step lost or duplicated.
- enable=0 or hold=1: Q and prescaler frozen; target/state keep tracking; releasing resumes from the frozen prescaler count.
- Alarm: set on the edge after Q >= ALARM_LVL. Cleared on the edge after Q < ALARM_LVL-ALARM_HYST. Holds otherwise.
- settled/dir_up/dir_down decode state, so they are mutually exclusive and exactly one is high.
- Reset asserted mid-slew: immediate return to reset values; after release, normal re-convergence.

Decomposition:
- Package pressure_pkg: needle_state_t enum {SETTLED, RISE, FALL}, default parameter constants, saturating-multiply function.
- One sub-module: vol_level_quant (border -> vol_lvl, combinational, parametrised on VOL_STEP/NUM_VOL_LVL).

Test Plan:
- Reset release, border=120, temp=2, num_moles=1 (target 30) -> Q=30, settled=1 throughout, dir_up=dir_down=0.
- border=250, temp=7, num_moles=7 at edge 0, enable=1 -> target=95 at edge 1, dir_up at edge 2, first Q=31 at edge 6, Q=95 at edge 262, settled at edge 263.
- Same slew: alarm rises the edge after Q=60. Then drop to target 30 -> alarm stays high until Q=55, clears next edge.
- hold=1 for 10 cycles mid-rise at Q=40 -> Q stays 40, target keeps updating; release -> next step after the remaining prescaler count.
- Reversal at Q=50 rising (target switched to 20) -> dir_down next edge, prescaler cleared, first decrement STEP_DIV edges later, no overshoot past 20.
- clearn pulsed low (async, between edges) at Q=70 -> Q=30, alarm=0 immediately; re-converges to the current target after release.

Source files
------------

// File: rtl/pressure_pkg.sv
// Shared types, default parameters and arithmetic helpers for the pressure needle controller.
package pressure_pkg;

  typedef enum logic [1:0] {
    SETTLED = 2'd0,
    RISE    = 2'd1,
    FALL    = 2'd2
  } needle_state_t;

  localparam int unsigned DEF_Q_W         = 7;
  localparam int unsigned DEF_BORDER_W    = 8;
  localparam int unsigned DEF_LVL_W       = 3;
  localparam int unsigned DEF_VOL_STEP    = 50;
  localparam int unsigned DEF_NUM_VOL_LVL = 5;
  localparam int unsigned DEF_SCALE       = 5;
  localparam int unsigned DEF_STEP_DIV    = 4;
  localparam int unsigned DEF_RESET_POS   = 30;
  localparam int unsigned DEF_ALARM_LVL   = 60;
  localparam int unsigned DEF_ALARM_HYST  = 4;

  // Product a*b computed wide enough never to wrap, then clamped to max_val.
  function automatic int unsigned sat_mul(input int unsigned a, input int unsigned b,
                                          input int unsigned max_val);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    if (prod > 64'(max_val)) return max_val;
    return prod[31:0];
  endfunction

endpackage

// File: rtl/vol_level_quant.sv
// Quantises piston border position into a 1-based volume level, clamped at the top bucket.
module vol_level_quant #(
  parameter int unsigned BORDER_W    = 8,
  parameter int unsigned VOL_STEP    = 50,
  parameter int unsigned NUM_VOL_LVL = 5,
  parameter int unsigned OUT_W       = 3
) (
  input  logic [BORDER_W-1:0] border,
  output logic [OUT_W-1:0]    vol_lvl
);

  logic [31:0] bucket;

  // Bucket index plus one, saturated to the number of buckets.
  always_comb begin
    bucket  = 32'(border) / VOL_STEP + 32'd1;
    vol_lvl = (bucket > NUM_VOL_LVL) ? OUT_W'(NUM_VOL_LVL) : OUT_W'(bucket);
  end

endmodule

// File: rtl/pressure_needle_ctrl.sv
// Pressure needle controller: registered target from volume/temperature/moles,
// prescaled slew of the needle toward it, and a hysteretic over-pressure alarm.
//
// state   | meaning
// SETTLED | needle equals target, prescaler idle at zero
// RISE    | target above needle, needle steps up every STEP_DIV enabled clocks
// FALL    | target below needle, needle steps down every STEP_DIV enabled clocks
module pressure_needle_ctrl
  import pressure_pkg::*;
#(
  parameter int unsigned Q_W         = DEF_Q_W,
  parameter int unsigned BORDER_W    = DEF_BORDER_W,
  parameter int unsigned LVL_W       = DEF_LVL_W,
  parameter int unsigned VOL_STEP    = DEF_VOL_STEP,
  parameter int unsigned NUM_VOL_LVL = DEF_NUM_VOL_LVL,
  parameter int unsigned SCALE       = DEF_SCALE,
  parameter int unsigned STEP_DIV    = DEF_STEP_DIV,
  parameter int unsigned RESET_POS   = DEF_RESET_POS,
  parameter int unsigned ALARM_LVL   = DEF_ALARM_LVL,
  parameter int unsigned ALARM_HYST  = DEF_ALARM_HYST
) (
  input  logic                clk,
  input  logic                clearn,
  input  logic                enable,
  input  logic                hold,
  input  logic [LVL_W-1:0]    temp,
  input  logic [LVL_W-1:0]    num_moles,
  input  logic [BORDER_W-1:0] border,
  output logic [Q_W-1:0]      Q,
  output logic [Q_W-1:0]      target,
  output logic                settled,
  output logic                dir_up,
  output logic                dir_down,
  output logic                alarm
);

  localparam int unsigned VOL_W = $clog2(NUM_VOL_LVL + 1);
  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [VOL_W-1:0] vol_lvl;
  logic [Q_W-1:0]   sum_sat;
  needle_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [Q_W-1:0]   q_nxt;
  logic             alarm_nxt;
  logic             reversal;

  vol_level_quant #(
    .BORDER_W   (BORDER_W),
    .VOL_STEP   (VOL_STEP),
    .NUM_VOL_LVL(NUM_VOL_LVL),
    .OUT_W      (VOL_W)
  ) u_vol_level_quant (
    .border (border),
    .vol_lvl(vol_lvl)
  );

  assign sum_sat = Q_W'(sat_mul(32'(vol_lvl) + 32'(temp) + 32'(num_moles), SCALE,
                                (32'd1 << Q_W) - 32'd1));

  // State register.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) state <= SETTLED;
    else         state <= state_nxt;
  end

  // Next state follows the needle/target relation every clock.
  always_comb begin
    state_nxt = SETTLED;
    if (target > Q)      state_nxt = RISE;
    else if (target < Q) state_nxt = FALL;
  end

  // Status outputs are a one-hot decode of the state.
  always_comb begin
    settled  = (state == SETTLED);
    dir_up   = (state == RISE);
    dir_down = (state == FALL);
  end

  // Prescaler and needle step; a step only happens while the registered
  // direction still agrees with the live comparison, so the needle cannot overshoot.
  always_comb begin
    cnt_nxt  = cnt;
    q_nxt    = Q;
    reversal = ((state == RISE) && (state_nxt == FALL)) ||
               ((state == FALL) && (state_nxt == RISE));
    if ((state_nxt == SETTLED) || reversal) begin
      cnt_nxt = '0;
    end else if (enable && !hold && (state != SETTLED)) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt = '0;
        q_nxt   = (state == RISE) ? Q + 1'b1 : Q - 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Alarm sets at or above the threshold and clears only below the hysteresis band.
  always_comb begin
    alarm_nxt = alarm;
    if (Q >= Q_W'(ALARM_LVL))                   alarm_nxt = 1'b1;
    else if (Q < Q_W'(ALARM_LVL - ALARM_HYST)) alarm_nxt = 1'b0;
  end

  // Datapath registers: target tracks inputs unconditionally.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      target <= Q_W'(RESET_POS);
      Q      <= Q_W'(RESET_POS);
      cnt    <= '0;
      alarm  <= 1'b0;
    end else begin
      target <= sum_sat;
      Q      <= q_nxt;
      cnt    <= cnt_nxt;
      alarm  <= alarm_nxt;
    end
  end

endmodule

// File: tb/tb_pressure_needle_ctrl.sv
// Self-checking bench for pressure_needle_ctrl: target table, directed slew
// corner cases and randomized traffic against a behavioural model.
module tb_pressure_needle_ctrl;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic       enable = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] temp = 3'd2;
  logic [2:0] num_moles = 3'd1;
  logic [7:0] border = 8'd120;
  logic [6:0] Q, target;
  logic       settled, dir_up, dir_down, alarm;

  int n_pass = 0;
  int n_total = 0;

  pressure_needle_ctrl dut (
    .clk(clk), .clearn(clearn), .enable(enable), .hold(hold),
    .temp(temp), .num_moles(num_moles), .border(border),
    .Q(Q), .target(target), .settled(settled), .dir_up(dir_up),
    .dir_down(dir_down), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Behavioural reference model: needle position, target, direction (-1/0/+1),
  // enabled-clock count since the last step, alarm.
  int m_q = 30, m_tgt = 30, m_dir = 0, m_cnt = 0, m_alarm = 0;
  int nd, nq, nc, na;

  function automatic int calc_tgt(int b, int t, int m);
    int v, s;
    v = b / 50 + 1;
    if (v > 5) v = 5;
    s = (v + t + m) * 5;
    if (s > 127) s = 127;
    return s;
  endfunction

  always @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      m_q = 30; m_tgt = 30; m_dir = 0; m_cnt = 0; m_alarm = 0;
    end else begin
      nd = (m_tgt > m_q) ? 1 : ((m_tgt < m_q) ? -1 : 0);
      nq = m_q;
      nc = m_cnt;
      if (nd == 0 || nd == -m_dir) nc = 0;
      else if (m_dir != 0 && enable && !hold) begin
        if (nc == 3) begin nc = 0; nq = m_q + m_dir; end
        else nc = nc + 1;
      end
      na = (m_q >= 60) ? 1 : ((m_q < 56) ? 0 : m_alarm);
      m_tgt = calc_tgt(int'(border), int'(temp), int'(num_moles));
      m_q = nq; m_cnt = nc; m_dir = nd; m_alarm = na;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_all();
    chk("q", int'(Q), m_q);
    chk("target", int'(target), m_tgt);
    chk("settled", int'(settled), int'(m_dir == 0));
    chk("dir_up", int'(dir_up), int'(m_dir == 1));
    chk("dir_down", int'(dir_down), int'(m_dir == -1));
    chk("alarm", int'(alarm), m_alarm);
  endtask

  task automatic edge_chk();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input int b, input int t, input int m);
    border = 8'(b); temp = 3'(t); num_moles = 3'(m);
  endtask

  task automatic run_until(input int qv, input bit need_settled, input int bound, input string nm);
    bit done;
    done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      edge_chk();
      if (int'(Q) == qv && (!need_settled || settled)) done = 1;
    end
    if (!done) chk({nm, "_timeout"}, 0, 1);
    else chk(nm, int'(Q), qv);
  endtask

  typedef struct {
    int b;
    int t;
    int m;
    int exp_tgt;
  } vec_t;

  vec_t vecs[11];
  bit   seen55;
  bit   done;

  initial begin
    vecs[0]  = '{0, 0, 0, 5};
    vecs[1]  = '{49, 0, 0, 5};
    vecs[2]  = '{50, 0, 0, 10};
    vecs[3]  = '{199, 3, 3, 50};
    vecs[4]  = '{200, 0, 0, 25};
    vecs[5]  = '{255, 7, 7, 95};
    vecs[6]  = '{100, 7, 7, 85};
    vecs[7]  = '{149, 7, 6, 80};
    vecs[8]  = '{250, 7, 7, 95};
    vecs[9]  = '{0, 2, 1, 20};
    vecs[10] = '{120, 2, 1, 30};

    // Reset state with target equal to the reset position.
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_q", int'(Q), 30);
    chk("rst_alarm", int'(alarm), 0);
    clearn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge_chk();
      chk("idle_settled", int'(settled), 1);
      chk("idle_q", int'(Q), 30);
      chk("idle_dirs", int'(dir_up | dir_down), 0);
    end

    // Target table with motion disabled.
    foreach (vecs[i]) begin
      set_in(vecs[i].b, vecs[i].t, vecs[i].m);
      edge_chk();
      chk("tbl_target", int'(target), vecs[i].exp_tgt);
      chk("tbl_q_frozen", int'(Q), 30);
    end
    edge_chk();
    edge_chk();

    // Full slew 30 -> 95 with latency and alarm timing.
    set_in(250, 7, 7);
    enable = 1'b1;
    for (int e = 1; e <= 263; e++) begin
      edge_chk();
      if (e == 1) chk("slew_target", int'(target), 95);
      if (e == 2) chk("slew_dir_up", int'(dir_up), 1);
      if (e == 5) chk("slew_q_e5", int'(Q), 30);
      if (e == 6) chk("slew_q_e6", int'(Q), 31);
      if (e == 122) chk("alarm_before", int'(alarm), 0);
      if (e == 123) chk("alarm_after", int'(alarm), 1);
      if (e == 262) begin
        chk("slew_q_end", int'(Q), 95);
        chk("slew_not_settled", int'(settled), 0);
      end
      if (e == 263) chk("slew_settled", int'(settled), 1);
    end

    // Drop to 30: alarm held through the hysteresis band.
    set_in(120, 2, 1);
    seen55 = 0;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      edge_chk();
      if (int'(Q) == 55 && !seen55) begin
        seen55 = 1;
        chk("alarm_at_55", int'(alarm), 1);
        edge_chk();
        chk("alarm_clear", int'(alarm), 0);
      end
      if (int'(Q) == 30 && settled) done = 1;
    end
    chk("drop_done", int'(done), 1);
    chk("drop_seen55", int'(seen55), 1);

    // Hold mid-rise at 40 with prescaler count 2.
    set_in(250, 7, 7);
    run_until(40, 0, 200, "reach_40");
    edge_chk();
    edge_chk();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) set_in(250, 7, 6);
      edge_chk();
      chk("hold_q", int'(Q), 40);
    end
    chk("hold_target", int'(target), 90);
    hold = 1'b0;
    edge_chk();
    chk("release_q1", int'(Q), 40);
    edge_chk();
    chk("release_q2", int'(Q), 41);

    // Reversal at 50 toward 20.
    run_until(50, 0, 200, "reach_50");
    set_in(0, 2, 1);
    edge_chk();
    chk("rev_target", int'(target), 20);
    edge_chk();
    chk("rev_dir_down", int'(dir_down), 1);
    for (int e = 3; e <= 6; e++) begin
      edge_chk();
      if (e == 5) chk("rev_q_e5", int'(Q), 50);
      if (e == 6) chk("rev_q_e6", int'(Q), 49);
    end
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      edge_chk();
      chk("no_overshoot", int'(Q >= 7'd20), 1);
      if (settled) done = 1;
    end
    chk("rev_final", int'(Q), 20);

    // Asynchronous reset mid-slew at 70.
    set_in(250, 7, 7);
    run_until(70, 0, 400, "reach_70");
    #2 clearn = 1'b0;
    #1;
    chk("arst_q", int'(Q), 30);
    chk("arst_alarm", int'(alarm), 0);
    chk("arst_target", int'(target), 30);
    chk("arst_settled", int'(settled), 1);
    @(negedge clk);
    #2 clearn = 1'b1;
    run_until(95, 1, 400, "reconverge");

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0)
        set_in(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 19) == 0) enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) hold = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1999) == 0) begin
        #2 clearn = 1'b0;
        #2 clearn = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      check_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
